// File: rtl/actor_arb_pkg.sv
// Shared types and constants for the actor token arbiter.
package actor_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_N_REQ     = 4;
  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_COUNT_W   = 16;
  localparam int unsigned DEF_MAX_BURST = 16;

  // Ceiling log2, usable in constant expressions; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/actor_rr_pick.sv
// Rotating-priority pick: first set request at or above ptr_i, wrapping.
module actor_rr_pick
  import actor_arb_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0]        req_i,
  input  logic [clog2(N_REQ)-1:0] ptr_i,
  output logic                    found_o,
  output logic [clog2(N_REQ)-1:0] idx_o
);

  localparam int unsigned IDX_W = clog2(N_REQ);

  int unsigned cand;

  // Scan N_REQ candidates starting at ptr_i; the first hit wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = (32'(ptr_i) + k) % N_REQ;
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/actor_token_arbiter.sv
// Round-robin arbiter sharing one actor input port between N_REQ producers,
// granting a bounded burst per producer and rotating priority afterwards.
module actor_token_arbiter
  import actor_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = DEF_N_REQ,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned COUNT_W   = DEF_COUNT_W,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [N_REQ-1:0]           req_SEND,
  input  logic [N_REQ*DATA_W-1:0]    req_DATA,
  input  logic [N_REQ*COUNT_W-1:0]   req_COUNT,
  output logic [N_REQ-1:0]           req_ACK,
  output logic                       result_SEND,
  output logic [DATA_W-1:0]          result_DATA,
  output logic [COUNT_W-1:0]         result_COUNT,
  input  logic                       result_ACK,
  output logic [clog2(N_REQ)-1:0]    grant_id,
  output logic                       busy
);

  localparam int unsigned IDX_W = clog2(N_REQ);
  localparam logic [COUNT_W-1:0] MAX_B = COUNT_W'(MAX_BURST);
  localparam logic [COUNT_W-1:0] ONE   = COUNT_W'(1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [COUNT_W-1:0] rem_q, rem_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [COUNT_W-1:0] pick_cnt;
  logic [COUNT_W-1:0] load_cnt;
  logic [IDX_W-1:0]   next_ptr;
  logic               in_burst;
  logic               g_send;
  logic               accept;

  actor_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req_i   (req_SEND),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign in_burst = (state_q == BURST);
  assign g_send   = req_SEND[grant_q];
  assign accept   = in_burst & g_send & result_ACK;
  assign next_ptr = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
  assign pick_cnt = req_COUNT[pick_idx*COUNT_W +: COUNT_W];

  // Burst length at grant: COUNT clipped to MAX_BURST; a zero COUNT with SEND high still moves one token.
  always_comb begin
    load_cnt = pick_cnt;
    if (pick_cnt == '0)      load_cnt = ONE;
    else if (pick_cnt > MAX_B) load_cnt = MAX_B;
  end

  // State, grant, pointer and burst counter registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      rem_q    <= rem_d;
    end
  end

  // Next-state logic and the combinational output mux onto the granted producer.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    rem_d        = rem_q;
    req_ACK      = '0;
    result_SEND  = 1'b0;
    result_DATA  = '0;
    result_COUNT = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          rem_d   = load_cnt;
          state_d = BURST;
        end
      end
      BURST: begin
        result_SEND  = g_send;
        result_DATA  = req_DATA[grant_q*DATA_W +: DATA_W];
        result_COUNT = rem_q;
        if (accept) begin
          req_ACK[grant_q] = 1'b1;
          if (rem_q == ONE) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end else begin
            rem_d = rem_q - ONE;
          end
        end else if (!g_send) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_id = grant_q;
  assign busy     = in_burst;

endmodule

// File: tb/tb_actor_token_arbiter.sv
// Directed bench for actor_token_arbiter with a cycle-level reference model.
module tb_actor_token_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 16;
  localparam int MB = 16;
  localparam int IW = 2;

  logic            CLK;
  logic            RESET;
  logic [N-1:0]    req_SEND;
  logic [N*DW-1:0] req_DATA;
  logic [N*CW-1:0] req_COUNT;
  logic [N-1:0]    req_ACK;
  logic            result_SEND;
  logic [DW-1:0]   result_DATA;
  logic [CW-1:0]   result_COUNT;
  logic            result_ACK;
  logic [IW-1:0]   grant_id;
  logic            busy;

  actor_token_arbiter #(
    .N_REQ     (N),
    .DATA_W    (DW),
    .COUNT_W   (CW),
    .MAX_BURST (MB)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .req_SEND     (req_SEND),
    .req_DATA     (req_DATA),
    .req_COUNT    (req_COUNT),
    .req_ACK      (req_ACK),
    .result_SEND  (result_SEND),
    .result_DATA  (result_DATA),
    .result_COUNT (result_COUNT),
    .result_ACK   (result_ACK),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: who owns the port, how many tokens are left, where the next search starts.
  bit m_act;
  int m_own;
  int m_left;
  int m_next;

  function automatic int model_pick(input logic [N-1:0] s, input int start);
    for (int k = 0; k < N; k++) begin
      if (s[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic int burst_len(input int i);
    int c;
    c = int'(req_COUNT[i*CW +: CW]);
    if (c == 0) return 1;
    if (c > MB) return MB;
    return c;
  endfunction

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_act  <= 1'b0;
      m_own  <= 0;
      m_left <= 0;
      m_next <= 0;
    end else if (!m_act) begin
      if (model_pick(req_SEND, m_next) >= 0) begin
        m_act  <= 1'b1;
        m_own  <= model_pick(req_SEND, m_next);
        m_left <= burst_len(model_pick(req_SEND, m_next));
      end
    end else if (req_SEND[m_own] && result_ACK) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_act  <= 1'b0;
        m_next <= (m_own + 1) % N;
      end
    end else if (!req_SEND[m_own]) begin
      m_act  <= 1'b0;
      m_next <= (m_own + 1) % N;
    end
  end

  function automatic logic [31:0] exp_vec();
    logic          s;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic [N-1:0]  a;
    s = m_act && req_SEND[m_own];
    d = m_act ? req_DATA[m_own*DW +: DW] : '0;
    c = m_act ? CW'(m_left) : '0;
    a = '0;
    if (s && result_ACK) a[m_own] = 1'b1;
    return {m_act, IW'(m_own), s, d, c, a};
  endfunction

  // Every cycle: all DUT outputs against the model.
  always @(negedge CLK) begin
    check("cycle{busy,gid,send,data,count,ack}",
          {busy, grant_id, result_SEND, result_DATA, result_COUNT, req_ACK}, exp_vec());
  end

  // Bookkeeping for burst-level checks.
  int  ack_cnt [N];
  int  grants[$];
  int  lens[$];
  int  gaps[$];
  bit  prev_busy;
  bit  seen;
  int  blen;
  int  idle_len;

  task automatic mon();
    for (int i = 0; i < N; i++) ack_cnt[i] += int'(req_ACK[i]);
    if (busy) begin
      if (!prev_busy) begin
        grants.push_back(int'(grant_id));
        if (seen) gaps.push_back(idle_len);
        blen = 0;
      end
      blen++;
    end else begin
      if (prev_busy) begin
        lens.push_back(blen);
        seen     = 1'b1;
        idle_len = 0;
      end
      idle_len++;
    end
    prev_busy = busy;
  endtask

  always @(negedge CLK) if (RESET) mon();

  task automatic clear_mon();
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    grants.delete();
    lens.delete();
    gaps.delete();
    prev_busy = 1'b0;
    seen      = 1'b0;
    blen      = 0;
    idle_len  = 0;
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic set_cnt(input int i, input int v);
    req_COUNT[i*CW +: CW] = CW'(v);
  endtask

  task automatic do_reset();
    RESET      = 1'b0;
    req_SEND   = '0;
    req_COUNT  = '0;
    result_ACK = 1'b0;
    nxt();
    nxt();
    RESET = 1'b1;
    clear_mon();
  endtask

  initial begin
    RESET      = 1'b0;
    req_SEND   = '0;
    req_COUNT  = '0;
    result_ACK = 1'b0;
    req_DATA   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    clear_mon();

    // Reset state
    nxt();
    check("rst_busy", busy, 0);
    check("rst_send", result_SEND, 0);
    check("rst_ack", req_ACK, 0);
    check("rst_gid", grant_id, 0);
    check("rst_count", result_COUNT, 0);
    check("rst_data", result_DATA, 0);

    // Single requester, COUNT=3, ACK held
    do_reset();
    set_cnt(2, 3);
    req_SEND   = 4'b0100;
    result_ACK = 1'b1;
    smp();
    check("t1_idle_first", busy, 0);
    nxt(); smp();
    check("t1_gid", grant_id, 2);
    check("t1_busy", busy, 1);
    check("t1_cnt3", result_COUNT, 3);
    check("t1_data", result_DATA, 8'hC2);
    check("t1_ack", req_ACK, 4'b0100);
    nxt(); smp();
    check("t1_cnt2", result_COUNT, 2);
    nxt(); smp();
    check("t1_cnt1", result_COUNT, 1);
    check("t1_ack3", req_ACK, 4'b0100);
    nxt(); smp();
    check("t1_gap_idle", busy, 0);
    check("t1_gap_ack", req_ACK, 0);
    nxt(); smp();
    check("t1_regrant_busy", busy, 1);
    check("t1_regrant_cnt", result_COUNT, 3);
    nxt();
    req_SEND = '0;
    smp();
    check("t1_drop_send", result_SEND, 0);
    check("t1_drop_ack", req_ACK, 0);
    nxt(); smp();
    check("t1_end_idle", busy, 0);
    check("t1_ack_pulses", ack_cnt[2], 4);

    // Fairness: all four request, COUNT=100
    do_reset();
    for (int i = 0; i < N; i++) set_cnt(i, 100);
    req_SEND   = 4'hF;
    result_ACK = 1'b1;
    repeat (90) nxt();
    req_SEND = '0;
    check("fair_ngrants", grants.size() >= 5, 1);
    check("fair_nlens", lens.size() >= 4, 1);
    check("fair_ngaps", gaps.size() >= 4, 1);
    if (grants.size() >= 5) begin
      check("fair_g0", grants[0], 0);
      check("fair_g1", grants[1], 1);
      check("fair_g2", grants[2], 2);
      check("fair_g3", grants[3], 3);
      check("fair_g4", grants[4], 0);
    end
    for (int i = 0; i < 4 && i < lens.size(); i++) check("fair_len", lens[i], 16);
    for (int i = 0; i < 4 && i < gaps.size(); i++) check("fair_gap", gaps[i], 1);

    // Drain: producer 1 drops SEND after two ACKs
    do_reset();
    set_cnt(1, 5);
    req_SEND   = 4'b0010;
    result_ACK = 1'b1;
    nxt(); smp();
    check("dr_gid", grant_id, 1);
    check("dr_cnt5", result_COUNT, 5);
    check("dr_ack1", req_ACK, 4'b0010);
    nxt(); smp();
    check("dr_cnt4", result_COUNT, 4);
    nxt();
    req_SEND = '0;
    smp();
    check("dr_send_low", result_SEND, 0);
    check("dr_no_ack", req_ACK, 0);
    check("dr_cnt3", result_COUNT, 3);
    nxt(); smp();
    check("dr_idle", busy, 0);
    check("dr_ack_pulses", ack_cnt[1], 2);
    nxt();
    set_cnt(2, 2);
    req_SEND = 4'b0110;
    nxt(); smp();
    check("dr_next_from_2", grant_id, 2);
    req_SEND = '0;
    nxt(); nxt();

    // COUNT=0 with back-pressure: stray ACK in IDLE, then 0, then 1
    do_reset();
    set_cnt(3, 0);
    req_SEND   = 4'b1000;
    result_ACK = 1'b1;
    smp();
    check("c0_idle_ack", req_ACK, 0);
    nxt();
    result_ACK = 1'b0;
    smp();
    check("c0_gid", grant_id, 3);
    check("c0_cnt", result_COUNT, 1);
    check("c0_noack", req_ACK, 0);
    nxt();
    result_ACK = 1'b1;
    smp();
    check("c0_cnt_hold", result_COUNT, 1);
    check("c0_ack", req_ACK, 4'b1000);
    nxt();
    req_SEND = '0;
    smp();
    check("c0_end", busy, 0);
    check("c0_pulses", ack_cnt[3], 1);

    // Stray ACK while nothing is offered
    do_reset();
    result_ACK = 1'b1;
    nxt(); smp();
    check("st_idle_busy", busy, 0);
    check("st_idle_ack", req_ACK, 0);
    set_cnt(0, 4);
    req_SEND   = 4'b0001;
    result_ACK = 1'b0;
    nxt(); smp();
    check("st_cnt4", result_COUNT, 4);
    nxt();
    req_SEND   = '0;
    result_ACK = 1'b1;
    smp();
    check("st_send0_ack", req_ACK, 0);
    check("st_send0_cnt", result_COUNT, 4);
    nxt(); smp();
    check("st_end", busy, 0);
    result_ACK = 1'b0;

    // Async reset mid-burst, then search restarts at 0
    do_reset();
    set_cnt(2, 1);
    req_SEND   = 4'b0100;
    result_ACK = 1'b1;
    nxt(); smp();
    check("ar_first_gid", grant_id, 2);
    nxt();
    set_cnt(1, 8);
    set_cnt(3, 8);
    req_SEND = 4'b1010;
    smp();
    check("ar_gap", busy, 0);
    nxt(); smp();
    check("ar_gid3", grant_id, 3);
    check("ar_cnt8", result_COUNT, 8);
    nxt(); smp();
    check("ar_cnt7", result_COUNT, 7);
    #2 RESET = 1'b0;
    #1;
    check("ar_busy0", busy, 0);
    check("ar_send0", result_SEND, 0);
    check("ar_ack0", req_ACK, 0);
    check("ar_gid0", grant_id, 0);
    nxt();
    RESET = 1'b1;
    nxt(); smp();
    check("ar_restart_gid", grant_id, 1);
    check("ar_restart_busy", busy, 1);
    req_SEND   = '0;
    result_ACK = 1'b0;
    nxt(); nxt();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
